// File: rtl/bpm_pkg.sv
// ---------------------------------------------------------------------------
// bpm_pkg
// Shared types and constants for the tempo estimator.
//   bpm_state_t  : divider-control FSM states
//   MS_PER_MIN   : dividend used to turn an interval in ms into beats/minute
//   DIV_W        : width of the sequential divider datapath
//   min_int_ms() : shortest inter-beat interval for a given top tempo
//   max_int_ms() : longest inter-beat interval for a given bottom tempo
// ---------------------------------------------------------------------------
package bpm_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_UPDATE = 2'd2
    } bpm_state_t;

    localparam int MS_PER_MIN = 60000;
    localparam int DIV_W      = 16;

    function automatic int min_int_ms(input int max_bpm);
        return MS_PER_MIN / max_bpm;
    endfunction

    function automatic int max_int_ms(input int min_bpm);
        return MS_PER_MIN / min_bpm;
    endfunction

endpackage

// File: rtl/bpm_estimator_seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock.
// The first step is folded into the start cycle, so a start in cycle S
// gives busy during S+1..S+DIV_W-1 and a one-cycle done at S+DIV_W with the
// quotient valid from then on (held until the next start).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a division with dividend/divisor sampled this cycle
//   dividend   : DIV_W-bit numerator
//   divisor    : DIV_W-bit denominator (zero gives an all-ones quotient)
//   busy       : iterations still outstanding
//   done       : one-cycle strobe, quotient has just become valid
//   quotient   : DIV_W-bit result
// ---------------------------------------------------------------------------
module seq_divider
    import bpm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIV_W);

    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] step_rem_in;
    logic [DIV_W-1:0] step_quo_in;
    logic [DIV_W-1:0] step_dvs;
    logic [DIV_W:0]   trial;
    logic [DIV_W-1:0] diff;
    logic             step_bit;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        step_rem_in = rem_q;
        step_quo_in = quo_q;
        step_dvs    = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // The start cycle runs the first step straight off the inputs.
        if (start) begin
            step_rem_in = '0;
            step_quo_in = dividend;
            step_dvs    = divisor;
        end

        // Shift the next dividend bit into the partial remainder and keep
        // the subtraction only if it does not go negative.
        trial = {step_rem_in, step_quo_in[DIV_W-1]};
        if (trial >= {1'b0, step_dvs}) begin
            diff     = DIV_W'(trial - {1'b0, step_dvs});
            step_bit = 1'b1;
        end else begin
            diff     = trial[DIV_W-1:0];
            step_bit = 1'b0;
        end

        if (start) begin
            rem_d  = diff;
            quo_d  = {step_quo_in[DIV_W-2:0], step_bit};
            dvs_d  = divisor;
            cnt_d  = CNT_W'(DIV_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = diff;
            quo_d = {step_quo_in[DIV_W-2:0], step_bit};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath registers are reset as well, so a divide
            // aborted by reset never leaves a stale quotient behind.
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/bpm_estimator.sv
// ---------------------------------------------------------------------------
// bpm_estimator
// Envelope follower + hysteretic beat detector on a signed audio stream.
// Inter-beat intervals are timed in ms, divided into 60000 by seq_divider,
// clamped and smoothed into a tempo estimate.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   sample_in       : signed 16-bit audio sample
//   sample_valid    : sample_in is valid this cycle
//   BPM_estimate    : smoothed tempo, 0 when no live estimate
//   bpm_valid       : BPM_estimate is live
//   pulse_amplitude : env[15:8] captured at the last accepted beat
//   beat_pulse      : one-cycle strobe per accepted beat
// ---------------------------------------------------------------------------
module bpm_estimator
    import bpm_pkg::*;
#(
    parameter int          MIN_BPM     = 40,
    parameter int          MAX_BPM     = 200,
    parameter int          TICK_DIV    = 50_000,
    parameter int          DECAY_SHIFT = 10,
    parameter logic [15:0] THRESH_HI   = 16'd8192,
    parameter logic [15:0] THRESH_LO   = 16'd4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [15:0]           sample_in,
    input  logic                         sample_valid,
    output logic [$clog2(MAX_BPM+1)-1:0] BPM_estimate,
    output logic                         bpm_valid,
    output logic [7:0]                   pulse_amplitude,
    output logic                         beat_pulse
);

    localparam int BPM_W      = $clog2(MAX_BPM + 1);
    localparam int SUM_W      = BPM_W + 3;
    localparam int MIN_INT_MS = min_int_ms(MAX_BPM);
    localparam int MAX_INT_MS = max_int_ms(MIN_BPM);
    localparam int INT_W      = $clog2(MAX_INT_MS + 2);
    localparam int TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    bpm_state_t        state_q, state_d;
    logic [15:0]       env_q, env_d;
    logic              armed_q, armed_d;
    logic              first_seen_q, first_seen_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [INT_W-1:0]  interval_q, interval_d;
    logic [INT_W-1:0]  int_lat_q, int_lat_d;
    logic              div_req_q, div_req_d;
    logic              kill_q, kill_d;
    logic              beat_pulse_q, beat_pulse_d;
    logic [7:0]        amp_q, amp_d;
    logic [BPM_W-1:0]  bpm_est_q, bpm_est_d;
    logic              bpm_valid_q, bpm_valid_d;

    logic [15:0]       abs_val;
    logic              fire;
    logic              too_soon;
    logic              accept;
    logic              timeout;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DIV_W-1:0]  div_quotient;
    logic [BPM_W-1:0]  q_clamped;
    logic [SUM_W-1:0]  smooth_sum;

    // -----------------------------------------------------------------------
    // Rectifier and envelope follower
    // -----------------------------------------------------------------------
    always_comb begin
        // -32768 has no positive counterpart in 16 bits, so it saturates.
        if (sample_in == 16'sh8000) begin
            abs_val = 16'h7FFF;
        end else if (sample_in[15]) begin
            abs_val = $unsigned(-sample_in);
        end else begin
            abs_val = $unsigned(sample_in);
        end

        env_d = env_q;
        if (sample_valid) begin
            if (abs_val > env_q) begin
                env_d = abs_val;
            end else begin
                env_d = env_q - (env_q >> DECAY_SHIFT);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Beat detection, interval timer and beat bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        fire     = armed_q && (env_q >= THRESH_HI);
        timeout  = (interval_q == INT_W'(MAX_INT_MS + 1));
        // Crossings closer than the fastest tempo are treated as the same
        // beat ringing, but only once a reference beat exists.
        too_soon = first_seen_q && (interval_q < INT_W'(MIN_INT_MS));
        accept   = fire && !too_soon;

        // Hysteresis: fire high, re-arm only after falling below THRESH_LO.
        armed_d = armed_q;
        if (fire) begin
            armed_d = 1'b0;
        end else if (env_q < THRESH_LO) begin
            armed_d = 1'b1;
        end

        tick_d     = tick_q;
        interval_d = interval_q;
        if (accept) begin
            tick_d     = '0;
            interval_d = '0;
        end else if (tick_q == TICK_W'(TICK_DIV - 1)) begin
            tick_d = '0;
            if (!timeout) begin
                interval_d = interval_q + INT_W'(1);
            end
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        beat_pulse_d = accept;
        amp_d        = accept ? env_q[15:8] : amp_q;
        int_lat_d    = accept ? interval_q : int_lat_q;

        // A beat coinciding with timeout counts as a fresh first beat.
        first_seen_d = first_seen_q;
        if (accept) begin
            first_seen_d = 1'b1;
        end else if (timeout) begin
            first_seen_d = 1'b0;
        end

        div_req_d = accept && first_seen_q && !timeout && (state_q == S_IDLE);
    end

    // -----------------------------------------------------------------------
    // Divider control FSM and estimate update
    // -----------------------------------------------------------------------
    always_comb begin
        if (div_quotient < DIV_W'(MIN_BPM)) begin
            q_clamped = BPM_W'(MIN_BPM);
        end else if (div_quotient > DIV_W'(MAX_BPM)) begin
            q_clamped = BPM_W'(MAX_BPM);
        end else begin
            q_clamped = BPM_W'(div_quotient);
        end
        smooth_sum = SUM_W'(bpm_est_q) * SUM_W'(3) + SUM_W'(q_clamped) + SUM_W'(2);

        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (div_req_q && !div_busy) begin
                    div_start = 1'b1;
                    state_d   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (div_done) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A timeout while a divide is in flight voids that divide's update.
        kill_d = kill_q;
        if (div_start) begin
            kill_d = 1'b0;
        end
        if (timeout) begin
            kill_d = 1'b1;
        end

        bpm_est_d   = bpm_est_q;
        bpm_valid_d = bpm_valid_q;
        if (timeout) begin
            bpm_est_d   = '0;
            bpm_valid_d = 1'b0;
        end else if ((state_q == S_UPDATE) && !kill_q) begin
            bpm_est_d   = bpm_valid_q ? BPM_W'(smooth_sum >> 2) : q_clamped;
            bpm_valid_d = 1'b1;
        end
    end

    seq_divider u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (DIV_W'(MS_PER_MIN)),
        .divisor  (DIV_W'(int_lat_q)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            env_q        <= '0;
            armed_q      <= 1'b0;
            first_seen_q <= 1'b0;
            tick_q       <= '0;
            interval_q   <= '0;
            int_lat_q    <= '0;
            div_req_q    <= 1'b0;
            kill_q       <= 1'b0;
            beat_pulse_q <= 1'b0;
            amp_q        <= '0;
            bpm_est_q    <= '0;
            bpm_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            env_q        <= env_d;
            armed_q      <= armed_d;
            first_seen_q <= first_seen_d;
            tick_q       <= tick_d;
            interval_q   <= interval_d;
            int_lat_q    <= int_lat_d;
            div_req_q    <= div_req_d;
            kill_q       <= kill_d;
            beat_pulse_q <= beat_pulse_d;
            amp_q        <= amp_d;
            bpm_est_q    <= bpm_est_d;
            bpm_valid_q  <= bpm_valid_d;
        end
    end

    assign BPM_estimate    = bpm_est_q;
    assign bpm_valid       = bpm_valid_q;
    assign pulse_amplitude = amp_q;
    assign beat_pulse      = beat_pulse_q;

endmodule

// File: tb/tb_bpm_estimator.sv
// ---------------------------------------------------------------------------
// tb_bpm_estimator
// Directed bench for bpm_estimator with TICK_DIV = 10 (10 clocks per ms).
// Inputs are driven right after a falling edge and outputs are observed on
// falling edges. A beat is one sample of a large value followed by zeros.
// ---------------------------------------------------------------------------
module tb_bpm_estimator;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic [7:0]         bpm_estimate;
    logic               bpm_valid;
    logic [7:0]         pulse_amplitude;
    logic               beat_pulse;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   tcount    = 0;
    int   t_ref     = 0;
    int   pulse_cnt = 0;
    int   snap_cnt  = 0;
    logic prev_pulse = 1'b0;

    always #5 clk = ~clk;

    bpm_estimator #(
        .TICK_DIV (10)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .BPM_estimate    (bpm_estimate),
        .bpm_valid       (bpm_valid),
        .pulse_amplitude (pulse_amplitude),
        .beat_pulse      (beat_pulse)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock with the given sample; returns on the next falling edge.
    task automatic tick(input logic signed [15:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        @(negedge clk);
        tcount++;
    endtask

    task automatic burst(input logic signed [15:0] s, input bit set_ref);
        if (set_ref) t_ref = tcount;
        tick(s);
    endtask

    // Pad with silence so the next burst lands ms*10+5 clocks after the
    // reference burst; the detector then measures exactly ms milliseconds.
    task automatic wait_ms(input int ms);
        while (tcount - t_ref < ms * 10 + 5) tick(16'sd0);
    endtask

    // Pulses must never be back to back.
    always @(negedge clk) begin
        if (beat_pulse) begin
            check("pulse_gap", 32'(prev_pulse), 0);
            pulse_cnt++;
        end
        prev_pulse = beat_pulse;
    end

    initial begin
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_bpm",   32'(bpm_estimate), 0);
        check("rst_valid", 32'(bpm_valid), 0);
        check("rst_amp",   32'(pulse_amplitude), 0);
        check("rst_pulse", 32'(beat_pulse), 0);
        reset = 1'b0;
        repeat (5) tick(16'sd0);

        // First beat: strobe, amplitude 20000>>8 = 0x4E, no estimate.
        burst(16'sd20000, 1'b1);
        tick(16'sd0);
        check("b1_pulse", 32'(beat_pulse), 1);
        check("b1_amp",   32'(pulse_amplitude), 'h4E);
        repeat (20) tick(16'sd0);
        check("b1_no_est", 32'(bpm_valid), 0);

        // Second beat 500 ms later: 60000/500 = 120, visible 18 cycles on.
        wait_ms(500);
        burst(16'sd20000, 1'b1);
        tick(16'sd0);
        check("b2_pulse", 32'(beat_pulse), 1);
        repeat (17) tick(16'sd0);
        check("b2_valid_early", 32'(bpm_valid), 0);
        tick(16'sd0);
        check("b2_valid", 32'(bpm_valid), 1);
        check("b2_bpm",   32'(bpm_estimate), 120);

        // 400 ms: q = 150, (3*120 + 150 + 2) >> 2 = 128.
        wait_ms(400);
        burst(16'sd20000, 1'b1);
        tick(16'sd0);
        check("b3_pulse", 32'(beat_pulse), 1);
        repeat (18) tick(16'sd0);
        check("b3_bpm", 32'(bpm_estimate), 128);

        // Crossing 200 ms later is suppressed; a larger burst shows that
        // the amplitude is not captured either.
        snap_cnt = pulse_cnt;
        wait_ms(200);
        burst(16'sd30000, 1'b0);
        tick(16'sd0);
        check("sup_pulse", 32'(beat_pulse), 0);
        repeat (40) tick(16'sd0);
        check("sup_cnt", 32'(pulse_cnt), 32'(snap_cnt));
        check("sup_amp", 32'(pulse_amplitude), 'h4E);
        check("sup_bpm", 32'(bpm_estimate), 128);

        // 500 ms from the last accepted beat: q = 120, (384+120+2)>>2 = 126.
        wait_ms(500);
        burst(16'sd20000, 1'b1);
        tick(16'sd0);
        check("b4_pulse", 32'(beat_pulse), 1);
        repeat (18) tick(16'sd0);
        check("b4_bpm", 32'(bpm_estimate), 126);

        // Timeout after 1501 ms without a beat.
        wait_ms(1499);
        check("pre_to_valid", 32'(bpm_valid), 1);
        check("pre_to_bpm",   32'(bpm_estimate), 126);
        wait_ms(1502);
        check("to_valid", 32'(bpm_valid), 0);
        check("to_bpm",   32'(bpm_estimate), 0);
        burst(16'sd20000, 1'b1);
        tick(16'sd0);
        check("b5_pulse", 32'(beat_pulse), 1);
        repeat (20) tick(16'sd0);
        check("b5_valid", 32'(bpm_valid), 0);
        check("b5_bpm",   32'(bpm_estimate), 0);

        // -32768 saturates to 32767 (amp 0x7F); 1400 ms gives q = 42.
        wait_ms(1400);
        burst(-16'sd32768, 1'b1);
        tick(16'sd0);
        check("b6_pulse", 32'(beat_pulse), 1);
        check("b6_amp",   32'(pulse_amplitude), 'h7F);
        repeat (18) tick(16'sd0);
        check("b6_valid", 32'(bpm_valid), 1);
        check("b6_bpm",   32'(bpm_estimate), 42);

        // Reset in the middle of a divide.
        wait_ms(500);
        burst(16'sd20000, 1'b1);
        tick(16'sd0);
        check("b7_pulse", 32'(beat_pulse), 1);
        repeat (5) tick(16'sd0);
        reset = 1'b1;
        tick(16'sd0);
        check("mid_rst_bpm",   32'(bpm_estimate), 0);
        check("mid_rst_valid", 32'(bpm_valid), 0);
        check("mid_rst_amp",   32'(pulse_amplitude), 0);
        check("mid_rst_pulse", 32'(beat_pulse), 0);
        reset = 1'b0;
        repeat (30) tick(16'sd0);
        check("post_rst_valid", 32'(bpm_valid), 0);
        check("post_rst_bpm",   32'(bpm_estimate), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
